// File: rtl/alarm_trigger_unit.sv
// Weekday alarm sequencer: matches the day's stored alarm word against the
// current time and runs the ring / snooze / timeout state machine.
module alarm_trigger_unit #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [12:0] Q_r0,
    input  logic [12:0] Q_r1,
    input  logic [12:0] Q_r2,
    input  logic [12:0] Q_r3,
    input  logic [12:0] Q_r4,
    input  logic [12:0] Q_r5,
    input  logic [12:0] Q_r6,
    input  logic [2:0]  Day,
    input  logic [4:0]  Hour,
    input  logic [5:0]  Minute,
    input  logic        Second_tick,
    input  logic        Snooze,
    input  logic        Stop,
    output logic        Buzzer,
    output logic        Snoozing,
    output logic [2:0]  Active_idx,
    output logic        Missed
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [CW-1:0] RING_LIM   = CW'(RING_SECS);
    localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_SECS);
    localparam logic [SW-1:0] SNZ_LIM    = SW'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] sec_cnt, sec_nxt, sec_inc;
    logic [SW-1:0] snz_cnt, snz_nxt;
    logic [2:0]    idx_nxt;
    logic          missed_nxt, buzzer_nxt, snoozing_nxt;
    logic          fired, fired_eff, fired_nxt;
    logic [5:0]    prev_min;
    logic [11:0]   word;
    logic          match, trigger;
    logic          rsvd_unused;

    // Bit 11 of each alarm word is reserved and deliberately ignored.
    assign rsvd_unused = ^{Q_r0[11], Q_r1[11], Q_r2[11], Q_r3[11],
                           Q_r4[11], Q_r5[11], Q_r6[11]};

    always_comb begin
        word = '0;
        case (Day)
            3'd0:    word = {Q_r0[12], Q_r0[10:0]};
            3'd1:    word = {Q_r1[12], Q_r1[10:0]};
            3'd2:    word = {Q_r2[12], Q_r2[10:0]};
            3'd3:    word = {Q_r3[12], Q_r3[10:0]};
            3'd4:    word = {Q_r4[12], Q_r4[10:0]};
            3'd5:    word = {Q_r5[12], Q_r5[10:0]};
            3'd6:    word = {Q_r6[12], Q_r6[10:0]};
            default: word = '0;
        endcase
    end

    assign match = (Day <= 3'd6) && word[11] && (word[10:6] == Hour) && (word[5:0] == Minute);

    // fired only survives while the minute is unchanged since the last edge,
    // so a new minute can trigger on its very first cycle.
    assign fired_eff = fired && (Minute == prev_min);
    assign trigger   = (state == IDLE) && match && !fired_eff;
    assign fired_nxt = match || fired_eff;
    assign sec_inc   = sec_cnt + CW'(1);

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            snz_cnt    <= '0;
            Active_idx <= '0;
            fired      <= 1'b0;
            prev_min   <= '0;
            Buzzer     <= 1'b0;
            Snoozing   <= 1'b0;
            Missed     <= 1'b0;
        end else begin
            state      <= state_nxt;
            sec_cnt    <= sec_nxt;
            snz_cnt    <= snz_nxt;
            Active_idx <= idx_nxt;
            fired      <= fired_nxt;
            prev_min   <= Minute;
            Buzzer     <= buzzer_nxt;
            Snoozing   <= snoozing_nxt;
            Missed     <= missed_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sec_nxt    = sec_cnt;
        snz_nxt    = snz_cnt;
        idx_nxt    = Active_idx;
        missed_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = RING;
                    sec_nxt   = '0;
                    snz_nxt   = '0;
                    idx_nxt   = Day;
                end
            end
            RING: begin
                if (Stop) begin
                    state_nxt = IDLE;
                end else if (Snooze && (snz_cnt < SNZ_LIM)) begin
                    state_nxt = SNOOZE;
                    snz_nxt   = snz_cnt + SW'(1);
                    sec_nxt   = '0;
                end else if (Second_tick) begin
                    if (sec_inc == RING_LIM) begin
                        state_nxt  = IDLE;
                        missed_nxt = 1'b1;
                        sec_nxt    = '0;
                    end else begin
                        sec_nxt = sec_inc;
                    end
                end
            end
            SNOOZE: begin
                if (Stop) begin
                    state_nxt = IDLE;
                end else if (Second_tick) begin
                    if (sec_inc == SNOOZE_LIM) begin
                        state_nxt = RING;
                        sec_nxt   = '0;
                    end else begin
                        sec_nxt = sec_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state.
    always_comb begin
        buzzer_nxt   = (state_nxt == RING);
        snoozing_nxt = (state_nxt == SNOOZE);
    end

endmodule

// File: tb/tb_alarm_trigger_unit.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle,
// a monitor pops one entry on every observed change of the output bundle.
module tb_alarm_trigger_unit;

    localparam logic [12:0] W730 = 13'b1_0_00111_011110;
    localparam logic [5:0]  RG   = 6'b100_010;  // {Buzzer,Snoozing,Missed,Active_idx}
    localparam logic [5:0]  SN   = 6'b010_010;
    localparam logic [5:0]  ID   = 6'b000_010;
    localparam logic [5:0]  MS   = 6'b001_010;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [12:0] Q_r0, Q_r1, Q_r2, Q_r3, Q_r4, Q_r5, Q_r6;
    logic [2:0]  Day;
    logic [4:0]  Hour;
    logic [5:0]  Minute;
    logic        Second_tick, Snooze, Stop;
    logic        Buzzer, Snoozing, Missed;
    logic [2:0]  Active_idx;

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    alarm_trigger_unit #(.RING_SECS(4), .SNOOZE_SECS(6), .MAX_SNOOZE(2)) dut (
        .Clock(Clock), .Clear(Clear),
        .Q_r0(Q_r0), .Q_r1(Q_r1), .Q_r2(Q_r2), .Q_r3(Q_r3),
        .Q_r4(Q_r4), .Q_r5(Q_r5), .Q_r6(Q_r6),
        .Day(Day), .Hour(Hour), .Minute(Minute),
        .Second_tick(Second_tick), .Snooze(Snooze), .Stop(Stop),
        .Buzzer(Buzzer), .Snoozing(Snoozing), .Active_idx(Active_idx), .Missed(Missed)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic expect_at(input int dc, input logic [5:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.val  = v;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic ticks(input int n, input int ne, input logic [5:0] v1,
                         input logic [5:0] v2, input string nm);
        for (int i = 0; i < n; i++) begin
            Second_tick = 1'b1;
            if (i == n - 1) begin
                if (ne >= 1) expect_at(1, v1, nm);
                if (ne >= 2) expect_at(2, v2, {nm, "_end"});
            end
            step(1);
            Second_tick = 1'b0;
            step(1);
        end
    endtask

    // Leave the minute and come back so fired clears and the alarm re-arms.
    task automatic retrigger(input string nm);
        Minute = 6'd31;
        step(2);
        Minute = 6'd30;
        expect_at(1, RG, nm);
        step(3);
    endtask

    // Monitor: compares every change of the output bundle against the queue.
    initial begin
        logic [5:0] last, cur;
        exp_t e;
        last = 6'b0;
        forever begin
            @(negedge Clock or negedge Clear);
            #1;
            cur = {Buzzer, Snoozing, Missed, Active_idx};
            if (cur !== last) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                             cur, cyc, last);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.name, cur, cyc, e.val, e.cyc);
                    end
                end
                last = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Clear = 1'b0;
        Q_r0 = '0; Q_r1 = '0; Q_r2 = '0; Q_r4 = '0; Q_r5 = '0; Q_r6 = '0;
        Q_r3 = 13'b1_0_00111_011111;  // enabled, but 07:31
        Day = 3'd0; Hour = 5'd7; Minute = 6'd30;
        Second_tick = 1'b0; Snooze = 1'b0; Stop = 1'b0;

        #3;
        checks++;
        if ({Buzzer, Snoozing, Missed, Active_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b, required 000000",
                     {Buzzer, Snoozing, Missed, Active_idx});
        end
        step(1);
        Clear = 1'b1;
        step(2);

        // No trigger: disabled word, other day's word, Day = 7.
        Q_r2 = W730 & 13'h0FFF; Day = 3'd2; step(3);
        Q_r2 = W730; Day = 3'd3; step(3);
        Day = 3'd7; step(3);

        // Basic trigger, Stop, no retrigger in the same minute.
        Day = 3'd2;
        expect_at(1, RG, "trigger");
        step(4);
        Stop = 1'b1;
        expect_at(1, ID, "stop");
        step(1);
        Stop = 1'b0;
        step(5);

        // Ring timeout.
        retrigger("trig_timeout");
        ticks(4, 2, MS, ID, "timeout");
        step(3);

        // Snooze cycles; word edits and held Snooze during SNOOZE do nothing.
        retrigger("trig_snooze");
        Snooze = 1'b1;
        expect_at(1, SN, "snooze1");
        step(1);
        Snooze = 1'b0;
        step(1);
        Snooze = 1'b1; Q_r2 = '0;
        step(2);
        Snooze = 1'b0;
        ticks(6, 1, RG, 6'b0, "rering1");
        Q_r2 = W730;
        step(1);
        Snooze = 1'b1;
        expect_at(1, SN, "snooze2");
        step(1);
        Snooze = 1'b0;
        step(1);
        ticks(6, 1, RG, 6'b0, "rering2");
        step(1);
        Snooze = 1'b1;  // third snooze is ignored
        step(2);
        Snooze = 1'b0;
        step(1);
        ticks(4, 2, MS, ID, "timeout_after_max");
        step(3);

        // Stop beats Snooze.
        retrigger("trig_prio");
        Stop = 1'b1; Snooze = 1'b1;
        expect_at(1, ID, "prio");
        step(1);
        Stop = 1'b0; Snooze = 1'b0;
        step(3);

        // Asynchronous Clear mid-snooze, then a single retrigger.
        retrigger("trig_rst");
        Snooze = 1'b1;
        expect_at(1, SN, "snooze_rst");
        step(1);
        Snooze = 1'b0;
        ticks(2, 0, 6'b0, 6'b0, "");
        #2;
        expect_at(0, 6'b0, "async_clear");
        Clear = 1'b0;
        step(1);
        ticks(3, 0, 6'b0, 6'b0, "");
        Clear = 1'b1;
        expect_at(1, RG, "retrig_after_clear");
        step(3);
        Stop = 1'b1;
        expect_at(1, ID, "stop_after_clear");
        step(1);
        Stop = 1'b0;
        step(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_trigger_unit.md
ALARM_TRIGGER_UNIT -- requirements
Module: alarm_trigger_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RING_SECS, 60: seconds Buzzer stays on before auto-timeout.
- SNOOZE_SECS, 300: seconds spent in snooze before re-ring.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1: single clock; all state on rising edge.
- Clear, in, 1: asynchronous, active-low reset.
- Q_r0..Q_r6, in, 13 each: stored alarm words, one per weekday (r0 = Sunday). Bit [12] = enable, bit [11] = reserved (ignored), bits [10:6] = hour 0-23, bits [5:0] = minute 0-59.
- Day, in, 3: current weekday 0-6.
- Hour, in, 5: current hour.
- Minute, in, 6: current minute.
- Second_tick, in, 1: one-Clock pulse per second.
- Snooze, in, 1: level, sampled per Clock.
- Stop, in, 1: level, sampled per Clock.
- Buzzer, out, 1: alarm sounding.
- Snoozing, out, 1: high in SNOOZE state.
- Active_idx, out, 3: register index of the current or last alarm event.
- Missed, out, 1: one-Clock pulse on ring timeout.

Function
REQ-003 The block SHALL be a 3-state FSM: IDLE, RING, SNOOZE.
REQ-004 Match SHALL be true when all of these hold: Day <= 6; the selected word Q_r[Day] has bit [12] = 1; word[10:6] == Hour; word[5:0] == Minute.
REQ-005 Day = 7 SHALL never match.
REQ-006 An internal fired flag SHALL permit one trigger per matching minute. It is set on trigger and cleared when Minute differs from its value on the previous Clock.
REQ-007 In IDLE, when Match is true and fired = 0, the FSM SHALL enter RING on the next edge. At that edge Active_idx <= Day, the snooze count <= 0 and the second counter <= 0. Buzzer SHALL be high starting that cycle (1-Clock latency from the sampled match).
REQ-008 In RING, input priority SHALL be Stop > Snooze > timeout.
REQ-009 In RING, Stop SHALL return the FSM to IDLE with Buzzer low on the next cycle.
REQ-010 In RING, Snooze with snooze count < MAX_SNOOZE SHALL go to SNOOZE, increment the snooze count and clear the second counter.
REQ-011 In RING, Snooze with snooze count == MAX_SNOOZE SHALL be ignored and the FSM SHALL stay in RING.
REQ-012 In RING, the counter SHALL increment on each Second_tick. On the tick that brings it to RING_SECS, the FSM SHALL go to IDLE and Missed SHALL pulse high for one Clock.
REQ-013 In SNOOZE, Stop SHALL go to IDLE.
REQ-014 In SNOOZE, the counter SHALL increment on each Second_tick. On reaching SNOOZE_SECS, the FSM SHALL go to RING and the counter SHALL clear.
REQ-015 Snooze held high in SNOOZE SHALL have no effect.
REQ-016 A new match while in RING or SNOOZE SHALL be ignored, but SHALL still set fired.
REQ-017 Changes to Q_r* while in RING or SNOOZE SHALL NOT affect the current event.
REQ-018 Counters SHALL be wide enough for SNOOZE_SECS and SHALL never wrap within a state.
REQ-019 Snoozing SHALL equal (state == SNOOZE). Buzzer SHALL equal (state == RING). Both SHALL be registered.

Reset
REQ-020 Clear = 0 SHALL immediately force: state IDLE, Buzzer 0, Snoozing 0, Missed 0, Active_idx 0, counters 0, fired 0.
REQ-021 Clear asserted mid-RING or mid-SNOOZE SHALL abort the event with no Missed pulse.
REQ-022 After Clear deasserts, a match still present in the same minute SHALL trigger once.

Verification (bench uses RING_SECS = 4, SNOOZE_SECS = 6, MAX_SNOOZE = 2)
REQ-023 Basic trigger: Q_r2 = 13'b1_0_00111_011110 (07:30 enabled), Day = 2, Hour = 7, Minute = 30 -> Buzzer = 1 one Clock later, Active_idx = 2. Hold the inputs -> no retrigger after Stop.
REQ-024 Disabled or wrong day: the same word with bit [12] = 0, or with Day = 3, or with Day = 7 -> Buzzer stays 0.
REQ-025 Timeout: from RING, apply 4 Second_ticks -> Missed pulses once, Buzzer = 0, state IDLE.
REQ-026 Snooze cycle: Snooze in RING -> Snoozing = 1. After 6 ticks -> Buzzer = 1. Repeat -> the third Snooze is ignored and Buzzer stays 1.
REQ-027 Priority: Stop and Snooze asserted together in RING -> IDLE, Snoozing stays 0.
REQ-028 Reset mid-snooze: Clear = 0 during SNOOZE -> all outputs 0 asynchronously and Missed never pulses. Release Clear in the same matching minute -> a single new trigger.
